mult_unit: RTL and testbench
============================

# mult_unit

Sequential 8x8 shift-add multiplier in the execute stage, directly downstream of the register file. It takes the two register-file read values as operands and produces a 16-bit product. The product goes back through the register file's single write port in two consecutive write cycles, low byte first, then high byte. While `busy` is high, the controller stalls issue and gives the write port to this block.

## Interface
Parameters: none. Datapath width is fixed at 8 bits, matching the register file.

Ports (clock and reset first):
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  reset, asynchronous, active-high
- `start`  in  1  request a multiply; sampled only in IDLE
- `is_signed`  in  1  1 = two's-complement operands, 0 = unsigned; latched with `start`
- `op_a`  in  8  multiplicand, from register-file `data_a`
- `op_b`  in  8  multiplier, from register-file `data_b`
- `dest_lo`  in  2  register that receives product[7:0]
- `dest_hi`  in  2  register that receives product[15:8]
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse during WB_HI
- `wb_en`  out  1  register-file write enable
- `wb_reg`  out  2  register-file write address
- `wb_value`  out  8  register-file write data

## Operation
- State register and outputs:
  - States: IDLE, MUL, NEG, WB_LO, WB_HI.
  - Outputs are Moore-decoded from the state register and datapath registers only.
- IDLE:
  - `start`=1 at an edge latches `dest_lo`, `dest_hi` and `is_signed`.
  - Latches mcand = |op_a| and mplier = |op_b|; magnitudes apply only when `is_signed`=1.
  - Latches neg = is_signed & (op_a[7] ^ op_b[7]).
  - Clears the 16-bit accumulator `prod` and the 3-bit counter `cnt`, then enters MUL.
  - |-128| = 128 as unsigned 8 bits, so mcand and mplier are 8-bit unsigned.
- MUL, one iteration per edge:
  - If mplier[0]=1, add mcand into `prod` at weight 2^cnt.
  - Then mplier >>= 1 and cnt++.
  - After the iteration with cnt==7: go to NEG if neg=1, else to WB_LO.
  - All arithmetic is 16-bit unsigned. The maximum result, 255*255 = 0xFE01, cannot overflow.
- NEG: `prod` <= ~`prod` + 1 (16-bit two's complement), then go to WB_LO.
- WB_LO: `wb_en`=1, `wb_reg`=dest_lo, `wb_value`=prod[7:0]; next state WB_HI.
- WB_HI: `wb_en`=1, `wb_reg`=dest_hi, `wb_value`=prod[15:8], `done`=1; next state IDLE.
- In all other states `wb_en`=0, `done`=0, and `wb_reg`/`wb_value` are driven to 0.
- Boundary rules:
  - `start` while busy is ignored: no latch and no effect on the operation in flight.
  - Zero operands take the full latency; there is no early termination.
  - `dest_lo`==`dest_hi`: both writes occur, and the high byte, written last, is the final register value.
  - `start` asserted in the WB_HI cycle is ignored. A new operation may start on the first IDLE cycle, so back-to-back issue has no gap beyond IDLE.
  - Operand ports are don't-care after the start edge, because the block uses latched copies only.
- Reset, at any time including mid-operation:
  - Forces state = IDLE and clears `prod`, `cnt`, mcand, mplier, neg and the latched destinations.
  - No write is issued for an aborted operation.
  - Reset values: `busy`=0, `done`=0, `wb_en`=0, `wb_reg`=0, `wb_value`=0.

## Timing
- Edge E0 samples `start` in IDLE; `busy` rises in the cycle after E0.
- MUL occupies exactly 8 cycles, edges E1..E8.
- Unsigned, or signed with non-negative result:
  - WB_LO in the cycle after E8, WB_HI after E9, IDLE after E10.
  - `busy` is high for 10 cycles.
- Signed with negative result: NEG adds one cycle; WB_LO after E9, WB_HI after E10, `busy` high for 11 cycles.
- Register-file writes land at the edge ending WB_LO and the edge ending WB_HI.
- Start-to-result latency: 10 or 11 cycles.
- Throughput: one multiply per 11 or 12 cycles, counting the mandatory IDLE cycle.

## Test plan
- Unsigned basic:
  - Stimulus: `op_a`=13, `op_b`=11, `is_signed`=0, dest_lo=2, dest_hi=3.
  - Response: WB_LO writes 0x8F to r2, WB_HI writes 0x00 to r3, `done` in the 10th busy cycle.
- Unsigned max: 0xFF * 0xFF -> lo 0x01, hi 0xFE; no overflow.
- Signed:
  - -3 * 5 (0xFD, 0x05) -> lo 0xF1, hi 0xFF, with 11 busy cycles via NEG.
  - -128 * -128 -> lo 0x00, hi 0x40, 10 busy cycles.
- Collisions and busy behaviour:
  - dest_lo = dest_hi = 1 with 7*40 -> r1 ends at 0x01, after the intermediate write of 0x18.
  - Pulse `start` with different operands in cycle 4 of MUL -> result unchanged, no extra writes.
- Reset mid-MUL:
  - Assert `reset` in cycle 5.
  - Response: `busy`, `wb_en` and `done` drop to 0 immediately; no writes follow.
  - A fresh 2*3 then yields lo 0x06, hi 0x00.

Source files
------------

// File: rtl/mult_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mult_unit: sequential 8x8 shift-add multiplier, two-cycle byte writeback |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mult_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       is_signed,
    input  logic [7:0] op_a,
    input  logic [7:0] op_b,
    input  logic [1:0] dest_lo,
    input  logic [1:0] dest_hi,
    output logic       busy,
    output logic       done,
    output logic       wb_en,
    output logic [1:0] wb_reg,
    output logic [7:0] wb_value
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MUL   = 3'd1,
        NEG   = 3'd2,
        WB_LO = 3'd3,
        WB_HI = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [15:0] prod;
    logic [2:0]  cnt;
    logic [7:0]  mcand;
    logic [7:0]  mplier;
    logic        neg;
    logic [1:0]  dlo;
    logic [1:0]  dhi;
    logic [15:0] addend;

    // Magnitude of -128 is 128, which still fits as an unsigned byte.
    function automatic logic [7:0] mag(input logic [7:0] v, input logic sgn);
        return (sgn && v[7]) ? (~v + 8'd1) : v;
    endfunction

    assign addend = mplier[0] ? ({8'd0, mcand} << cnt) : 16'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prod   <= 16'd0;
            cnt    <= 3'd0;
            mcand  <= 8'd0;
            mplier <= 8'd0;
            neg    <= 1'b0;
            dlo    <= 2'd0;
            dhi    <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= mag(op_a, is_signed);
                        mplier <= mag(op_b, is_signed);
                        neg    <= is_signed & (op_a[7] ^ op_b[7]);
                        dlo    <= dest_lo;
                        dhi    <= dest_hi;
                        prod   <= 16'd0;
                        cnt    <= 3'd0;
                    end
                end
                MUL: begin
                    prod   <= prod + addend;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 3'd1;
                end
                NEG: begin
                    prod <= ~prod + 16'd1;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b1;
        done     = 1'b0;
        wb_en    = 1'b0;
        wb_reg   = 2'd0;
        wb_value = 8'd0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nx = MUL;
            end
            MUL: begin
                if (cnt == 3'd7) state_nx = neg ? NEG : WB_LO;
            end
            NEG: begin
                state_nx = WB_LO;
            end
            WB_LO: begin
                wb_en    = 1'b1;
                wb_reg   = dlo;
                wb_value = prod[7:0];
                state_nx = WB_HI;
            end
            WB_HI: begin
                wb_en    = 1'b1;
                wb_reg   = dhi;
                wb_value = prod[15:8];
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                busy     = 1'b0;
                state_nx = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mult_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mult_unit: scoreboard bench for mult_unit                             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mult_unit;

    logic       clk;
    logic       reset;
    logic       start;
    logic       is_signed;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [1:0] dest_lo;
    logic [1:0] dest_hi;
    logic       busy;
    logic       done;
    logic       wb_en;
    logic [1:0] wb_reg;
    logic [7:0] wb_value;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [9:0] exp_q[$];
    logic [7:0] regs[4];

    mult_unit dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .is_signed(is_signed),
        .op_a     (op_a),
        .op_b     (op_b),
        .dest_lo  (dest_lo),
        .dest_hi  (dest_hi),
        .busy     (busy),
        .done     (done),
        .wb_en    (wb_en),
        .wb_reg   (wb_reg),
        .wb_value (wb_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Register-file writes are popped from the scoreboard as they appear.
    always @(negedge clk) begin
        if (wb_en) begin
            if (exp_q.size() == 0) begin
                check("unexpected_wb", 32'd1, 32'd0);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                check("wb_reg", 32'(wb_reg), 32'(e[9:8]));
                check("wb_value", 32'(wb_value), 32'(e[7:0]));
            end
            regs[wb_reg] = wb_value;
        end
    end

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                          input logic [1:0] dl, input logic [1:0] dh,
                          input int inj_at, input int rst_at);
        logic signed [15:0] sa, sb;
        logic [15:0]        p;
        int                 cycles;
        int                 done_at;
        int                 exp_busy;
        bit                 aborted;
        sa = {{8{a[7]}}, a};
        sb = {{8{b[7]}}, b};
        p  = s ? 16'(sa * sb) : ({8'd0, a} * {8'd0, b});
        exp_busy = (s && (a[7] ^ b[7])) ? 11 : 10;
        exp_q.push_back({dl, p[7:0]});
        exp_q.push_back({dh, p[15:8]});
        op_a = a; op_b = b; is_signed = s; dest_lo = dl; dest_hi = dh; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op_a = 8'($urandom); op_b = 8'($urandom);
        cycles = 0; done_at = 0; aborted = 0;
        while (busy && cycles < 20) begin
            cycles++;
            if (done) done_at = cycles;
            start = (cycles == inj_at);
            if (start) begin
                op_a = 8'($urandom); op_b = 8'($urandom);
                is_signed = ~s; dest_lo = ~dl; dest_hi = ~dh;
            end
            if (cycles == rst_at) begin
                reset = 1'b1;
                #1;
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_wb_en", 32'(wb_en), 32'd0);
                check("rst_done", 32'(done), 32'd0);
                exp_q.delete();
                aborted = 1;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (aborted) begin
            repeat (2) @(negedge clk);
            reset = 1'b0;
            repeat (12) @(negedge clk);
            check("post_rst_idle", 32'(busy), 32'd0);
        end else begin
            check("busy_cycles", 32'(cycles), 32'(exp_busy));
            check("done_cycle", 32'(done_at), 32'(exp_busy));
            check("sb_empty", 32'(exp_q.size()), 32'd0);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; is_signed = 1'b0;
        op_a = 8'd0; op_b = 8'd0; dest_lo = 2'd0; dest_hi = 2'd0;
        for (int i = 0; i < 4; i++) regs[i] = 8'd0;
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_wb_en", 32'(wb_en), 32'd0);
        check("reset_wb_reg", 32'(wb_reg), 32'd0);
        check("reset_wb_value", 32'(wb_value), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        run_op(8'd13, 8'd11, 1'b0, 2'd2, 2'd3, 0, 0);
        check("r2_final", 32'(regs[2]), 32'h8F);
        check("r3_final", 32'(regs[3]), 32'h00);
        run_op(8'hFF, 8'hFF, 1'b0, 2'd0, 2'd1, 0, 0);
        run_op(8'hFD, 8'h05, 1'b1, 2'd2, 2'd3, 0, 0);
        run_op(8'h80, 8'h80, 1'b1, 2'd0, 2'd1, 0, 0);
        run_op(8'hFB, 8'h00, 1'b1, 2'd3, 2'd2, 0, 0);
        run_op(8'h00, 8'h00, 1'b0, 2'd1, 2'd0, 0, 0);
        run_op(8'd7, 8'd40, 1'b0, 2'd1, 2'd1, 0, 0);
        check("r1_collision", 32'(regs[1]), 32'h01);
        run_op(8'd100, 8'd200, 1'b0, 2'd2, 2'd3, 4, 0);
        run_op(8'h7F, 8'h81, 1'b1, 2'd0, 2'd3, 0, 0);
        run_op(8'd9, 8'd9, 1'b0, 2'd0, 2'd1, 0, 5);
        run_op(8'd2, 8'd3, 1'b0, 2'd0, 2'd1, 0, 0);
        check("r0_after_rst", 32'(regs[0]), 32'h06);
        check("r1_after_rst", 32'(regs[1]), 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
